// File: rtl/axi4_lite_master_q.sv
// Queued AXI4-Lite master: command FIFO, in-order single-outstanding AXI issue, response port.
// Optional macro AXI4L_MASTER_ERRCNT_EN adds a saturating error-response counter (err_count).
module axi4_lite_master_q #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         CMD_DEPTH  = 4,
  parameter logic [2:0] AXI_PROT   = 3'b000
`ifdef AXI4L_MASTER_ERRCNT_EN
  ,
  parameter int         ERRCNT_WIDTH = 16
`endif
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  output logic                    m_AWVALID,
  input  logic                    m_AWREADY,
  output logic [ADDR_WIDTH-1:0]   m_AWADDR,
  output logic [2:0]              m_AWPROT,
  output logic                    m_WVALID,
  input  logic                    m_WREADY,
  output logic [DATA_WIDTH-1:0]   m_WDATA,
  output logic [DATA_WIDTH/8-1:0] m_WSTRB,
  input  logic                    m_BVALID,
  output logic                    m_BREADY,
  input  logic [1:0]              m_BRESP,
  output logic                    m_ARVALID,
  input  logic                    m_ARREADY,
  output logic [ADDR_WIDTH-1:0]   m_ARADDR,
  output logic [2:0]              m_ARPROT,
  input  logic                    m_RVALID,
  output logic                    m_RREADY,
  input  logic [DATA_WIDTH-1:0]   m_RDATA,
  input  logic [1:0]              m_RRESP
`ifdef AXI4L_MASTER_ERRCNT_EN
  ,
  output logic [ERRCNT_WIDTH-1:0] err_count
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH) + 1;
  localparam int ENT_W  = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RSP} state_t;

  state_t                 state, state_nxt;
  logic [ENT_W-1:0]       fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic                   empty, full, push, pop, ready_en;
  logic                   head_write;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic [DATA_WIDTH-1:0]  head_wdata;
  logic [STRB_W-1:0]      head_wstrb;
  logic                   aw_done, w_done, aw_hs, w_hs, ar_hs;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  // ready_en keeps req_ready low through reset and until the first edge after release
  assign req_ready = ready_en && !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !empty;

  assign {head_write, head_addr, head_wdata, head_wstrb} = fifo_mem[rd_ptr[PTR_W-2:0]];

  always_ff @(posedge iCLK) begin
    if (push) fifo_mem[wr_ptr[PTR_W-2:0]] <= {req_write, req_addr, req_wdata, req_wstrb};
  end

  assign aw_hs = m_AWVALID && m_AWREADY;
  assign w_hs  = m_WVALID && m_WREADY;
  assign ar_hs = m_ARVALID && m_ARREADY;

  assign rsp_valid = (state == RSP);
  assign m_BREADY  = (state == WRESP);
  assign m_RREADY  = (state == RDATA);
  assign busy      = (state != IDLE) || !empty;
  assign m_AWPROT  = AXI_PROT;
  assign m_ARPROT  = AXI_PROT;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = head_write ? WRITE : READ;
      WRITE:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WRESP;
      WRESP:   if (m_BVALID) state_nxt = RSP;
      READ:    if (ar_hs) state_nxt = RDATA;
      RDATA:   if (m_RVALID) state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // VALIDs are raised one cycle into WRITE/READ and dropped independently on their own handshake
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ready_en  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      m_AWVALID <= 1'b0;
      m_WVALID  <= 1'b0;
      m_ARVALID <= 1'b0;
    end else begin
      state     <= state_nxt;
      ready_en  <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      aw_done   <= (state == WRITE) && (aw_done || aw_hs);
      w_done    <= (state == WRITE) && (w_done || w_hs);
      m_AWVALID <= (state == WRITE) && !aw_done && !aw_hs;
      m_WVALID  <= (state == WRITE) && !w_done && !w_hs;
      m_ARVALID <= (state == READ) && !ar_hs;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      m_AWADDR  <= '0;
      m_WDATA   <= '0;
      m_WSTRB   <= '0;
      m_ARADDR  <= '0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            if (head_write) begin
              m_AWADDR <= head_addr;
              m_WDATA  <= head_wdata;
              m_WSTRB  <= head_wstrb;
            end else begin
              m_ARADDR <= head_addr;
            end
          end
        end
        WRESP: begin
          if (m_BVALID) begin
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= m_BRESP;
          end
        end
        RDATA: begin
          if (m_RVALID) begin
            rsp_write <= 1'b0;
            rsp_rdata <= m_RDATA;
            rsp_resp  <= m_RRESP;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXI4L_MASTER_ERRCNT_EN
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      err_count <= '0;
    end else if (rsp_valid && rsp_ready && (rsp_resp != 2'b00) && (err_count != '1)) begin
      err_count <= err_count + ERRCNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axi4_lite_master_q.sv
// Directed bench for axi4_lite_master_q with a small reactive AXI4-Lite slave model.
// Build with AXI4L_MASTER_ERRCNT_EN defined to also cover err_count (width 2).
module tb_axi4_lite_master_q;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic        m_AWVALID, m_AWREADY, m_WVALID, m_WREADY, m_BVALID, m_BREADY;
  logic        m_ARVALID, m_ARREADY, m_RVALID, m_RREADY;
  logic [31:0] m_AWADDR, m_WDATA, m_ARADDR, m_RDATA;
  logic [3:0]  m_WSTRB;
  logic [2:0]  m_AWPROT, m_ARPROT;
  logic [1:0]  m_BRESP, m_RRESP;
`ifdef AXI4L_MASTER_ERRCNT_EN
  logic [1:0]  err_count;
`endif

  int errors = 0;
  int checks = 0;

  axi4_lite_master_q #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .AXI_PROT(3'b000)
`ifdef AXI4L_MASTER_ERRCNT_EN
    , .ERRCNT_WIDTH(2)
`endif
  ) dut (
    .iCLK(clk), .iRST(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY), .m_AWADDR(m_AWADDR), .m_AWPROT(m_AWPROT),
    .m_WVALID(m_WVALID), .m_WREADY(m_WREADY), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
    .m_BVALID(m_BVALID), .m_BREADY(m_BREADY), .m_BRESP(m_BRESP),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR), .m_ARPROT(m_ARPROT),
    .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP)
`ifdef AXI4L_MASTER_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  // Slave model: READY rises after <delay> cycles of VALID; B/R are registered responses.
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  int          aw_wait, w_wait, ar_wait;
  int          aw_beats, w_beats, ar_beats, b_beats, together;
  int          bready_viol = 0;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  logic [31:0] mem [16];
  logic        s_ahs, s_whs, s_aall, s_wall;
  logic [31:0] s_wa, s_wd;

  assign m_AWREADY = (aw_wait >= aw_delay);
  assign m_WREADY  = (w_wait >= w_delay);
  assign m_ARREADY = (ar_wait >= ar_delay);
  assign s_ahs  = m_AWVALID && m_AWREADY;
  assign s_whs  = m_WVALID && m_WREADY;
  assign s_aall = aw_got || s_ahs;
  assign s_wall = w_got || s_whs;
  assign s_wa   = s_ahs ? m_AWADDR : aw_addr_q;
  assign s_wd   = s_whs ? m_WDATA : w_data_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_beats <= 0; w_beats <= 0; ar_beats <= 0; b_beats <= 0; together <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_addr_q <= '0; w_data_q <= '0;
      m_BVALID <= 1'b0; m_BRESP <= 2'b00;
      m_RVALID <= 1'b0; m_RDATA <= '0; m_RRESP <= 2'b00;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      aw_wait <= s_ahs ? 0 : (m_AWVALID ? aw_wait + 1 : 0);
      w_wait  <= s_whs ? 0 : (m_WVALID ? w_wait + 1 : 0);
      ar_wait <= (m_ARVALID && m_ARREADY) ? 0 : (m_ARVALID ? ar_wait + 1 : 0);
      if (s_ahs) begin aw_beats <= aw_beats + 1; aw_addr_q <= m_AWADDR; end
      if (s_whs) begin w_beats <= w_beats + 1; w_data_q <= m_WDATA; end
      if (s_ahs && s_whs) together <= together + 1;
      if (m_BVALID && m_BREADY) m_BVALID <= 1'b0;
      if (s_aall && s_wall) begin
        m_BVALID <= 1'b1;
        m_BRESP  <= bresp_cfg;
        b_beats  <= b_beats + 1;
        mem[s_wa[5:2]] <= s_wd;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= s_aall;
        w_got  <= s_wall;
      end
      if (m_RVALID && m_RREADY) m_RVALID <= 1'b0;
      if (m_ARVALID && m_ARREADY) begin
        m_RVALID <= 1'b1;
        m_RDATA  <= mem[m_ARADDR[5:2]];
        m_RRESP  <= rresp_cfg;
        ar_beats <= ar_beats + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_BREADY && (aw_beats != w_beats)) bready_viol <= bready_viol + 1;
  end

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = 4'hF;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit to);
    to = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (rsp_valid) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0]  ctl;
    logic [31:0] dat;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ctl = {req_ready, rsp_valid, busy, m_AWVALID, m_WVALID, m_BREADY,
           m_ARVALID, m_RREADY, rsp_write, |rsp_resp};
    dat = m_AWADDR | m_ARADDR | m_WDATA | rsp_rdata | {28'd0, m_WSTRB} | {26'd0, m_AWPROT, m_ARPROT};
    checks++;
    if (ctl !== 10'd0 || dat !== 32'd0) begin
      errors++; $display("FAIL reset_outputs: ctl=%b dat=%h required 0", ctl, dat);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b required 0", req_ready); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ready_after_edge: ready=%b busy=%b required 1/0", req_ready, busy);
    end
  endtask

  task automatic test_write();
    int aw0, w0, b0, t0;
    bit to;
    aw0 = aw_beats; w0 = w_beats; b0 = b_beats; t0 = together;
    push(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    checks++;
    if (m_AWVALID !== 1'b0) begin errors++; $display("FAIL wr_lat_n0: AWVALID=%b required 0", m_AWVALID); end
    @(negedge clk);
    checks++;
    if (m_AWVALID !== 1'b0) begin errors++; $display("FAIL wr_lat_n1: AWVALID=%b required 0", m_AWVALID); end
    @(negedge clk);
    checks++;
    if ({m_AWVALID, m_WVALID} !== 2'b11 || m_AWADDR !== 32'h1000 || m_WDATA !== 32'hDEADBEEF || m_WSTRB !== 4'hF) begin
      errors++;
      $display("FAIL wr_lat_n2: valid=%b addr=%h data=%h strb=%h required 11/1000/deadbeef/f",
               {m_AWVALID, m_WVALID}, m_AWADDR, m_WDATA, m_WSTRB);
    end
    wait_rsp(to);
    checks++;
    if (to) begin errors++; $display("FAIL wr_rsp_timeout: no response"); end
    checks++;
    if ({rsp_write, rsp_resp, rsp_rdata} !== {1'b1, 2'b00, 32'd0}) begin
      errors++; $display("FAIL wr_rsp: write=%b resp=%b rdata=%h required 1/00/0", rsp_write, rsp_resp, rsp_rdata);
    end
    checks++;
    if (aw_beats - aw0 != 1 || w_beats - w0 != 1 || b_beats - b0 != 1 || together - t0 != 1) begin
      errors++;
      $display("FAIL wr_beats: aw=%0d w=%0d b=%0d together=%0d required 1 each",
               aw_beats - aw0, w_beats - w0, b_beats - b0, together - t0);
    end
    ack_rsp();
  endtask

  task automatic test_read();
    int  ar0, n;
    bit  to, ok;
    ar0 = ar_beats;
    ar_delay = 3;
    push(1'b0, 32'h0000_1000, 32'h0);
    n = 0;
    while (!m_ARVALID && n < 20) begin @(negedge clk); n++; end
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!(m_ARVALID && !m_ARREADY && m_ARADDR == 32'h1000)) ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_ar_stable: held=%b required 1", ok); end
    checks++;
    if ({m_ARVALID, m_ARREADY} !== 2'b11 || m_ARADDR !== 32'h1000) begin
      errors++; $display("FAIL rd_ar_hs: valid/ready=%b addr=%h required 11/1000", {m_ARVALID, m_ARREADY}, m_ARADDR);
    end
    ar_delay = 0;
    wait_rsp(to);
    checks++;
    if (to || {rsp_write, rsp_resp, rsp_rdata} !== {1'b0, 2'b00, 32'hDEADBEEF} || ar_beats - ar0 != 1) begin
      errors++;
      $display("FAIL rd_rsp: to=%b write=%b resp=%b rdata=%h ar=%0d required 0/0/00/deadbeef/1",
               to, rsp_write, rsp_resp, rsp_rdata, ar_beats - ar0);
    end
    ack_rsp();
  endtask

  task automatic test_skew();
    int          aw0, w0, b0, v0;
    bit          to, split;
    logic [31:0] a, d;
    for (int k = 0; k < 2; k++) begin
      aw_delay = (k == 0) ? 4 : 0;
      w_delay  = (k == 0) ? 0 : 4;
      aw0 = aw_beats; w0 = w_beats; b0 = b_beats; v0 = bready_viol;
      a = 32'h300C + 32'(k * 4);
      d = 32'hA5A5_0001 + 32'(k);
      push(1'b1, a, d);
      split = 1'b0; to = 1'b1;
      for (int n = 0; n < 200; n++) begin
        if (rsp_valid) begin to = 1'b0; break; end
        if (k == 0 && m_AWVALID && !m_WVALID) split = 1'b1;
        if (k == 1 && m_WVALID && !m_AWVALID) split = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (to || !split) begin errors++; $display("FAIL skew%0d_split: to=%b split=%b required 0/1", k, to, split); end
      checks++;
      if (aw_beats - aw0 != 1 || w_beats - w0 != 1 || b_beats - b0 != 1 || bready_viol != v0) begin
        errors++;
        $display("FAIL skew%0d_beats: aw=%0d w=%0d b=%0d early_bready=%0d required 1/1/1/0",
                 k, aw_beats - aw0, w_beats - w0, b_beats - b0, bready_viol - v0);
      end
      checks++;
      if ({rsp_write, rsp_resp} !== 3'b100) begin
        errors++; $display("FAIL skew%0d_rsp: write=%b resp=%b required 1/00", k, rsp_write, rsp_resp);
      end
      ack_rsp();
    end
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_queue();
    logic        cw [5];
    logic [31:0] ca [5];
    logic [31:0] cd [5];
    logic [31:0] er [5];
    bit          to;
    cw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ca = '{32'h2004, 32'h2004, 32'h2008, 32'h2008, 32'h1000};
    cd = '{32'h1111_2222, 32'h0, 32'h3333_4444, 32'h0, 32'h0};
    er = '{32'h0, 32'h1111_2222, 32'h0, 32'h3333_4444, 32'hDEAD_BEEF};
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(cw[i], ca[i], cd[i]);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL q_ready_after4: got %b required 1", req_ready); end
    push(cw[4], ca[4], cd[4]);
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL q_full: ready=%b busy=%b required 0/1", req_ready, busy);
    end
    for (int i = 0; i < 5; i++) begin
      wait_rsp(to);
      if (i == 0) repeat (2) @(negedge clk);
      checks++;
      if (to || {rsp_valid, rsp_write, rsp_resp, rsp_rdata} !== {1'b1, cw[i], 2'b00, er[i]}) begin
        errors++;
        $display("FAIL q_rsp%0d: to=%b valid=%b write=%b resp=%b rdata=%h required 0/1/%b/00/%h",
                 i, to, rsp_valid, rsp_write, rsp_resp, rsp_rdata, cw[i], er[i]);
      end
      ack_rsp();
    end
  endtask

  task automatic test_errors();
    bit to;
`ifdef AXI4L_MASTER_ERRCNT_EN
    checks++;
    if (err_count !== 2'd0) begin errors++; $display("FAIL errcnt_start: got %0d required 0", err_count); end
`endif
    bresp_cfg = 2'b10;
    push(1'b1, 32'h3014, 32'h5555_AAAA);
    wait_rsp(to);
    checks++;
    if (to || {rsp_write, rsp_resp} !== 3'b110) begin
      errors++; $display("FAIL bresp_err: to=%b write=%b resp=%b required 0/1/10", to, rsp_write, rsp_resp);
    end
    ack_rsp();
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b11;
    push(1'b0, 32'h3014, 32'h0);
    wait_rsp(to);
    checks++;
    if (to || {rsp_write, rsp_resp, rsp_rdata} !== {1'b0, 2'b11, 32'h5555AAAA}) begin
      errors++;
      $display("FAIL rresp_err: to=%b write=%b resp=%b rdata=%h required 0/0/11/5555aaaa",
               to, rsp_write, rsp_resp, rsp_rdata);
    end
    ack_rsp();
`ifdef AXI4L_MASTER_ERRCNT_EN
    checks++;
    if (err_count !== 2'd2) begin errors++; $display("FAIL errcnt_two: got %0d required 2", err_count); end
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 32'h3014, 32'h0);
      wait_rsp(to);
      ack_rsp();
      checks++;
      if (to || err_count !== 2'd3) begin
        errors++; $display("FAIL errcnt_sat%0d: to=%b count=%0d required 0/3", i, to, err_count);
      end
    end
`endif
    rresp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  stale;
    logic [8:0] ctl;
    ar_delay = 50;
    push(1'b0, 32'h1000, 32'h0);
    push(1'b0, 32'h2004, 32'h0);
    push(1'b0, 32'h2008, 32'h0);
    n = 0;
    while (!m_ARVALID && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (m_ARVALID !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_setup: arvalid=%b busy=%b required 1/1", m_ARVALID, busy);
    end
    rst_n = 1'b0;
    #1;
    ctl = {m_ARVALID, m_AWVALID, m_WVALID, m_BREADY, m_RREADY, rsp_valid, req_ready, busy, |m_ARADDR};
    checks++;
    if (ctl !== 9'd0) begin errors++; $display("FAIL rst_async: outputs=%b required 0", ctl); end
    ar_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_release: busy=%b ready=%b required 0/0", busy, req_ready);
    end
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || m_ARVALID || m_AWVALID || busy) stale = 1'b1;
    end
    checks++;
    if (stale || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_stale: stale=%b ready=%b required 0/1", stale, req_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_skew();
    test_queue();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
